// File: rtl/arb2_stream_if.sv
// arb2_stream_if -- handshake/bus bundle for the two-source stream arbiter.
//   Sources a/b : *_valid, *_data toward the arbiter, *_ready back.
//   Select      : s (1 = a, 0 = b), current arbitration result.
//   Output      : f_valid, f_data toward the consumer, f_ready back.
// Modports: slave = arbiter side, master = environment (sources + consumer).
interface arb2_stream_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             s;
  logic             f_valid;
  logic [WIDTH-1:0] f_data;
  logic             f_ready;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, f_ready,
    output a_ready, b_ready, s, f_valid, f_data
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, f_ready,
    input  a_ready, b_ready, s, f_valid, f_data
  );
endinterface

// File: rtl/arb2_stream.sv
// arb2_stream -- round-robin arbiter in front of a 2:1 mux, with a one-entry
// output register. One word per clock; f_data/f_valid come straight from
// flops, so there is no combinational path from f_ready to f_data.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   io  : arb2_stream_if.slave (a/b streams, mux select s, output stream f)
// Build option: define ARB2_FIXED_PRIO_EN for fixed priority (a always beats
// b, no priority register). Default is round-robin.
module arb2_stream #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  arb2_stream_if.slave io
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} occ_e;

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             can_load, grant_a, grant_b, sel, load;

  assign can_load = (state_q == EMPTY) | io.f_ready;

`ifdef ARB2_FIXED_PRIO_EN
  assign grant_a = io.a_valid;
  assign grant_b = io.b_valid & ~grant_a;
  // Idle select parks on a.
  assign sel     = grant_a | (~io.a_valid & ~io.b_valid);
`else
  logic pri_q, pri_d;  // 1 = a has priority

  assign grant_a = io.a_valid & (~io.b_valid | pri_q);
  assign grant_b = io.b_valid & ~grant_a;
  // Idle select follows the pointer so s shows who would win next.
  assign sel     = grant_a | (~io.a_valid & ~io.b_valid & pri_q);

  // Winner drops to low priority; pointer moves only on a load.
  assign pri_d = load ? ~sel : pri_q;

  always_ff @(posedge clk) begin
    if (rst) pri_q <= 1'b1;
    else     pri_q <= pri_d;
  end
`endif

  // Readies are gated by rst so nothing is accepted during a reset cycle.
  assign load       = ~rst & can_load & (grant_a | grant_b);
  assign io.a_ready = ~rst & can_load & grant_a;
  assign io.b_ready = ~rst & can_load & grant_b;
  assign io.s       = sel;
  assign io.f_valid = (state_q == FULL);
  assign io.f_data  = data_q;

  // Occupancy FSM: load wins over drain, so drain+load keeps FULL with no bubble.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = sel ? io.a_data : io.b_data;
    end else if ((state_q == FULL) && io.f_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_arb2_stream.sv
// tb_arb2_stream -- directed table of {inputs, expected outputs} per cycle,
// plus a hand-written back-to-back alternation run.
// Per cycle: inputs driven 1 time unit after the rising edge, combinational
// outputs (a_ready, b_ready, s) checked before the next edge, registered
// outputs (f_valid, f_data) checked 1 unit after it.
module tb_arb2_stream;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  arb2_stream_if #(.WIDTH(8)) bus ();
  arb2_stream #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .io(bus.slave));

  typedef struct {
    logic       rst, av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       fr;
    logic       ar, br, s, fv;
    logic [7:0] fd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic av, logic [7:0] ad, logic bv,
                              logic [7:0] bd, logic fr, logic ar, logic br,
                              logic s, logic fv, logic [7:0] fd);
    vec_t v;
    v.rst = r; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.fr = fr;
    v.ar = ar; v.br = br; v.s = s; v.fv = fv; v.fd = fd;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic r, logic av, logic [7:0] ad, logic bv,
                       logic [7:0] bd, logic fr);
    rst = r; bus.a_valid = av; bus.a_data = ad;
    bus.b_valid = bv; bus.b_data = bd; bus.f_ready = fr;
  endtask

  initial begin
    //         rst av ad     bv bd     fr | ar br s  fv fd
`ifdef ARB2_FIXED_PRIO_EN
    tv.push_back(mk(1, 1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 0, 8'h00));
    tv.push_back(mk(1, 1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 0, 8'h00));
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(0, 1, 8'h11, 1, 8'h22, 1, 1, 0, 1, 1, 8'h11));
    tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 8'h11));
    tv.push_back(mk(0, 0, 8'h00, 1, 8'h44, 1, 0, 1, 0, 1, 8'h44));
`else
    // reset held 2 cycles with both sources valid
    tv.push_back(mk(1, 1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 0, 8'h00));
    tv.push_back(mk(1, 1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 0, 8'h00));
    // alternation a,b,a,b
    tv.push_back(mk(0, 1, 8'h11, 1, 8'h22, 1, 1, 0, 1, 1, 8'h11));
    tv.push_back(mk(0, 1, 8'h11, 1, 8'h22, 1, 0, 1, 0, 1, 8'h22));
    tv.push_back(mk(0, 1, 8'h11, 1, 8'h22, 1, 1, 0, 1, 1, 8'h11));
    tv.push_back(mk(0, 1, 8'h11, 1, 8'h22, 1, 0, 1, 0, 1, 8'h22));
    // single source b; pointer ends at a
    tv.push_back(mk(0, 0, 8'h00, 1, 8'h33, 1, 0, 1, 0, 1, 8'h33));
    tv.push_back(mk(0, 0, 8'h00, 1, 8'h34, 1, 0, 1, 0, 1, 8'h34));
    tv.push_back(mk(0, 0, 8'h00, 1, 8'h35, 1, 0, 1, 0, 1, 8'h35));
    // idle: s shows pri=A, register drains, data holds
    tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 8'h35));
    // backpressure: load a, stall 3 cycles with b waiting, then release
    tv.push_back(mk(0, 1, 8'h11, 0, 8'h00, 1, 1, 0, 1, 1, 8'h11));
    tv.push_back(mk(0, 0, 8'h00, 1, 8'h22, 0, 0, 0, 0, 1, 8'h11));
    tv.push_back(mk(0, 0, 8'h00, 1, 8'h22, 0, 0, 0, 0, 1, 8'h11));
    tv.push_back(mk(0, 0, 8'h00, 1, 8'h22, 0, 0, 0, 0, 1, 8'h11));
    tv.push_back(mk(0, 0, 8'h00, 1, 8'h22, 1, 0, 1, 0, 1, 8'h22));
    // reset mid-stall: load 0x55 (pri->B), stall, reset, then contention
    tv.push_back(mk(0, 1, 8'h55, 0, 8'h00, 1, 1, 0, 1, 1, 8'h55));
    tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 8'h55));
    tv.push_back(mk(1, 1, 8'h66, 1, 8'h77, 0, 0, 0, 0, 0, 8'h00));
    tv.push_back(mk(0, 1, 8'h66, 1, 8'h77, 1, 1, 0, 1, 1, 8'h66));
`endif

    // initial reset so the pointer is defined before the table starts
    drive(1, 0, 8'h00, 0, 8'h00, 0);
    @(posedge clk); #1;

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].av, tv[i].ad, tv[i].bv, tv[i].bd, tv[i].fr);
      #3;
      chk("a_ready", i, {7'b0, bus.a_ready}, {7'b0, tv[i].ar});
      chk("b_ready", i, {7'b0, bus.b_ready}, {7'b0, tv[i].br});
      chk("s",       i, {7'b0, bus.s},       {7'b0, tv[i].s});
      @(posedge clk); #1;
      chk("f_valid", i, {7'b0, bus.f_valid}, {7'b0, tv[i].fv});
      chk("f_data",  i, bus.f_data,          tv[i].fd);
    end

`ifndef ARB2_FIXED_PRIO_EN
    // Back-to-back with fresh data each cycle; a won last, so b goes first.
    for (int k = 0; k < 6; k++) begin
      logic       exp_s;
      logic [7:0] ad, bd;
      exp_s = k[0];
      ad = 8'hA0 + 8'(k);
      bd = 8'hB0 + 8'(k);
      drive(0, 1, ad, 1, bd, 1);
      #3;
      chk("rr_s",     100 + k, {7'b0, bus.s}, {7'b0, exp_s});
      chk("rr_ready", 100 + k, {6'b0, bus.a_ready, bus.b_ready},
          {6'b0, exp_s, ~exp_s});
      @(posedge clk); #1;
      chk("rr_data",  100 + k, bus.f_data, exp_s ? ad : bd);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
